// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared encodings for the multi-cycle CPU control unit:
//               opcodes, FSM states, ALU / write-back / PC select codes and
//               small opcode-classification helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int OPC_W = 5;

    // Bit 4 of the opcode marks the immediate (or PC-relative) form.
    localparam logic [OPC_W-1:0] OP_MV    = 5'b00000;
    localparam logic [OPC_W-1:0] OP_ADD   = 5'b00001;
    localparam logic [OPC_W-1:0] OP_SUB   = 5'b00010;
    localparam logic [OPC_W-1:0] OP_CMP   = 5'b00011;
    localparam logic [OPC_W-1:0] OP_LD    = 5'b00100;
    localparam logic [OPC_W-1:0] OP_ST    = 5'b00101;
    localparam logic [OPC_W-1:0] OP_JR    = 5'b01000;
    localparam logic [OPC_W-1:0] OP_JZR   = 5'b01001;
    localparam logic [OPC_W-1:0] OP_JNR   = 5'b01010;
    localparam logic [OPC_W-1:0] OP_CALLR = 5'b01100;
    localparam logic [OPC_W-1:0] OP_MVI   = 5'b10000;
    localparam logic [OPC_W-1:0] OP_ADDI  = 5'b10001;
    localparam logic [OPC_W-1:0] OP_SUBI  = 5'b10010;
    localparam logic [OPC_W-1:0] OP_CMPI  = 5'b10011;
    localparam logic [OPC_W-1:0] OP_MVHI  = 5'b10110;
    localparam logic [OPC_W-1:0] OP_J     = 5'b11000;
    localparam logic [OPC_W-1:0] OP_JZ    = 5'b11001;
    localparam logic [OPC_W-1:0] OP_JN    = 5'b11010;
    localparam logic [OPC_W-1:0] OP_CALL  = 5'b11100;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;

    localparam logic [2:0] WB_MEM   = 3'b000;
    localparam logic [2:0] WB_ALU   = 3'b001;
    localparam logic [2:0] WB_PC2   = 3'b010;
    localparam logic [2:0] WB_RY    = 3'b011;
    localparam logic [2:0] WB_IMM8  = 3'b100;
    localparam logic [2:0] WB_IMM8H = 3'b101;

    localparam logic [1:0] PC_BRANCH = 2'b00;
    localparam logic [1:0] PC_REG    = 2'b01;
    localparam logic [1:0] PC_NEXT   = 2'b10;

    // True for every opcode the control unit implements.
    function automatic logic op_is_defined(input logic [OPC_W-1:0] op);
        case (op)
            OP_MV, OP_ADD, OP_SUB, OP_CMP, OP_LD, OP_ST,
            OP_JR, OP_JZR, OP_JNR, OP_CALLR,
            OP_MVI, OP_ADDI, OP_SUBI, OP_CMPI, OP_MVHI,
            OP_J, OP_JZ, OP_JN, OP_CALL: return 1'b1;
            default:                     return 1'b0;
        endcase
    endfunction

    // True for the arithmetic ops whose ALU result updates N/Z.
    function automatic logic op_sets_flags(input logic [OPC_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_CMP, OP_ADDI, OP_SUBI, OP_CMPI: return 1'b1;
            default:                                           return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl_decode
// Description : Purely combinational control-vector decode from the current
//               FSM state, the opcode and the N/Z flags. Unused selects sit
//               at their idle defaults (WBSrc=ALU, PCSrc=PC+2).
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_ctrl_decode
    import cpu_pkg::*;
#(
    parameter int OPCODE_W = 5,
    parameter int ALUOP_W  = 2,
    parameter int WBSRC_W  = 3
) (
    input  state_e              state_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic                flag_n_i,
    input  logic                flag_z_i,
    output logic                mem_req_o,
    output logic                mem_sel_o,
    output logic                mem_write_o,
    output logic                reg_write_o,
    output logic                reg_dst_o,
    output logic [ALUOP_W-1:0]  alu_op_o,
    output logic                alu_src_o,
    output logic                ext_sel_o,
    output logic [WBSRC_W-1:0]  wb_src_o,
    output logic [1:0]          pc_src_o,
    output logic                pc_enable_o
);

    // Map state and opcode to the strobes and mux selects for this cycle.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_sel_o   = 1'b0;
        mem_write_o = 1'b0;
        reg_write_o = 1'b0;
        reg_dst_o   = 1'b0;
        alu_op_o    = ALU_ADD;
        alu_src_o   = 1'b0;
        ext_sel_o   = 1'b0;
        wb_src_o    = WB_ALU;
        pc_src_o    = PC_NEXT;
        pc_enable_o = 1'b0;

        case (state_i)
            S_FETCH: begin
                mem_req_o = 1'b1;
            end
            S_EXEC: begin
                pc_enable_o = 1'b1;
                case (opcode_i)
                    OP_MV:   begin reg_write_o = 1'b1; wb_src_o = WB_RY; end
                    OP_ADD:  begin reg_write_o = 1'b1; end
                    OP_ADDI: begin reg_write_o = 1'b1; alu_src_o = 1'b1; end
                    OP_SUB:  begin reg_write_o = 1'b1; alu_op_o = ALU_SUB; end
                    OP_SUBI: begin
                        reg_write_o = 1'b1;
                        alu_op_o    = ALU_SUB;
                        alu_src_o   = 1'b1;
                    end
                    OP_CMP:  begin alu_op_o = ALU_SUB; end
                    OP_CMPI: begin alu_op_o = ALU_SUB; alu_src_o = 1'b1; end
                    OP_MVI:  begin reg_write_o = 1'b1; wb_src_o = WB_IMM8; end
                    OP_MVHI: begin reg_write_o = 1'b1; wb_src_o = WB_IMM8H; end
                    OP_JR:   begin pc_src_o = PC_REG; end
                    OP_J:    begin pc_src_o = PC_BRANCH; ext_sel_o = 1'b1; end
                    OP_JZR:  begin if (flag_z_i) pc_src_o = PC_REG; end
                    OP_JNR:  begin if (flag_n_i) pc_src_o = PC_REG; end
                    OP_JZ: begin
                        if (flag_z_i) begin
                            pc_src_o  = PC_BRANCH;
                            ext_sel_o = 1'b1;
                        end
                    end
                    OP_JN: begin
                        if (flag_n_i) begin
                            pc_src_o  = PC_BRANCH;
                            ext_sel_o = 1'b1;
                        end
                    end
                    OP_CALLR: begin
                        pc_src_o    = PC_REG;
                        reg_write_o = 1'b1;
                        reg_dst_o   = 1'b1;
                        wb_src_o    = WB_PC2;
                    end
                    OP_CALL: begin
                        pc_src_o    = PC_BRANCH;
                        ext_sel_o   = 1'b1;
                        reg_write_o = 1'b1;
                        reg_dst_o   = 1'b1;
                        wb_src_o    = WB_PC2;
                    end
                    // ld/st only advance the PC here; undefined ops act as NOP.
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req_o   = 1'b1;
                mem_sel_o   = 1'b1;
                mem_write_o = (opcode_i == OP_ST);
            end
            S_WB: begin
                reg_write_o = 1'b1;
                wb_src_o    = WB_MEM;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : cpu_control_fsm
// Description : Multi-cycle CPU control unit. Sequences fetch / decode /
//               execute / memory / write-back over a shared memory port with
//               a ready handshake and a bounded wait. Owns the N/Z flags, the
//               retired-instruction counter and sticky error bits.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_control_fsm
    import cpu_pkg::*;
#(
    parameter int OPCODE_W = 5,
    parameter int ALUOP_W  = 2,
    parameter int WBSRC_W  = 3,
    parameter int TIMEOUT  = 64,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    input  logic                alu_n,
    input  logic                alu_z,
    output logic                ir_load,
    output logic                mem_req,
    output logic                mem_sel,
    output logic                MemWrite,
    output logic                RegWrite,
    output logic                RegDst,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                ALUSrc,
    output logic                ExtSel,
    output logic [WBSRC_W-1:0]  WBSrc,
    output logic [1:0]          PCSrc,
    output logic                pc_enable,
    output logic                flag_n,
    output logic                flag_z,
    output logic                busy,
    output logic                illegal_op,
    output logic                mem_timeout,
    output logic [CNT_W-1:0]    retired_count
);

    localparam int              WAIT_W   = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                retire_d;
    logic                timeout_d;
    logic                flag_n_q, flag_z_q;
    logic                illegal_q, timeout_q;
    logic [CNT_W-1:0]    count_q;

    // State and wait-counter register; reset aborts any transaction at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next state; the wait counter only survives while a request is stalled.
    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        retire_d  = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_MAX) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (opcode == OP_LD || opcode == OP_ST) begin
                    state_d = S_MEM;
                end else begin
                    state_d  = S_IDLE;
                    retire_d = 1'b1;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (opcode == OP_LD) begin
                        state_d = S_WB;
                    end else begin
                        state_d  = S_IDLE;
                        retire_d = 1'b1;
                    end
                end else if (wait_q == WAIT_MAX) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB: begin
                state_d  = S_IDLE;
                retire_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Architectural status: flags, sticky error bits and retire counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flag_n_q  <= 1'b0;
            flag_z_q  <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            count_q   <= '0;
        end else begin
            if (state_q == S_EXEC && op_sets_flags(opcode)) begin
                flag_n_q <= alu_n;
                flag_z_q <= alu_z;
            end
            if (state_q == S_DECODE && !op_is_defined(opcode)) begin
                illegal_q <= 1'b1;
            end
            if (timeout_d) begin
                timeout_q <= 1'b1;
            end
            if (retire_d) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    // Output decode: control vector from state/opcode/flags.
    cpu_ctrl_decode #(
        .OPCODE_W (OPCODE_W),
        .ALUOP_W  (ALUOP_W),
        .WBSRC_W  (WBSRC_W)
    ) u_decode (
        .state_i     (state_q),
        .opcode_i    (opcode),
        .flag_n_i    (flag_n_q),
        .flag_z_i    (flag_z_q),
        .mem_req_o   (mem_req),
        .mem_sel_o   (mem_sel),
        .mem_write_o (MemWrite),
        .reg_write_o (RegWrite),
        .reg_dst_o   (RegDst),
        .alu_op_o    (ALUOp),
        .alu_src_o   (ALUSrc),
        .ext_sel_o   (ExtSel),
        .wb_src_o    (WBSrc),
        .pc_src_o    (PCSrc),
        .pc_enable_o (pc_enable)
    );

    assign ir_load       = (state_q == S_FETCH) && mem_ready;
    assign busy          = (state_q != S_IDLE);
    assign flag_n        = flag_n_q;
    assign flag_z        = flag_z_q;
    assign illegal_op    = illegal_q;
    assign mem_timeout   = timeout_q;
    assign retired_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_control_fsm
// Description : Self-checking bench for cpu_control_fsm: directed table of
//               instructions, a mid-operation reset sequence and randomized
//               instructions checked cycle by cycle against an
//               instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_control_fsm;

    localparam int TB_TIMEOUT = 8;

    localparam logic [4:0] MV = 5'h00, ADD = 5'h01, SUB = 5'h02, CMP = 5'h03;
    localparam logic [4:0] LD = 5'h04, ST = 5'h05, JR = 5'h08, JZR = 5'h09;
    localparam logic [4:0] JNR = 5'h0A, CALLR = 5'h0C, MVI = 5'h10, ADDI = 5'h11;
    localparam logic [4:0] SUBI = 5'h12, CMPI = 5'h13, MVHI = 5'h16, J = 5'h18;
    localparam logic [4:0] JZ = 5'h19, JN = 5'h1A, CALL = 5'h1C;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run;
    logic [4:0]  opcode;
    logic        mem_ready;
    logic        alu_n, alu_z;
    logic        ir_load, mem_req, mem_sel, MemWrite, RegWrite, RegDst;
    logic [1:0]  ALUOp;
    logic        ALUSrc, ExtSel;
    logic [2:0]  WBSrc;
    logic [1:0]  PCSrc;
    logic        pc_enable, flag_n, flag_z, busy, illegal_op, mem_timeout;
    logic [31:0] retired_count;

    cpu_control_fsm #(
        .OPCODE_W (5),
        .ALUOP_W  (2),
        .WBSRC_W  (3),
        .TIMEOUT  (TB_TIMEOUT),
        .CNT_W    (32)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .run           (run),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .alu_n         (alu_n),
        .alu_z         (alu_z),
        .ir_load       (ir_load),
        .mem_req       (mem_req),
        .mem_sel       (mem_sel),
        .MemWrite      (MemWrite),
        .RegWrite      (RegWrite),
        .RegDst        (RegDst),
        .ALUOp         (ALUOp),
        .ALUSrc        (ALUSrc),
        .ExtSel        (ExtSel),
        .WBSrc         (WBSrc),
        .PCSrc         (PCSrc),
        .pc_enable     (pc_enable),
        .flag_n        (flag_n),
        .flag_z        (flag_z),
        .busy          (busy),
        .illegal_op    (illegal_op),
        .mem_timeout   (mem_timeout),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference architectural state.
    logic        m_fn, m_fz, m_ill, m_tmo;
    logic [31:0] m_cnt;

    logic [4:0] legal_ops [19] = '{MV, ADD, SUB, CMP, LD, ST, JR, JZR, JNR, CALLR,
                                   MVI, ADDI, SUBI, CMPI, MVHI, J, JZ, JN, CALL};

    wire [16:0] outvec = {ir_load, mem_req, mem_sel, MemWrite, RegWrite, RegDst,
                          ALUOp, ALUSrc, ExtSel, WBSrc, PCSrc, pc_enable, busy};

    function automatic logic [16:0] vec(input logic ir, mreq, msel, mw, rw, rd,
                                        input logic [1:0] aop, input logic asrc, ext,
                                        input logic [2:0] wb, input logic [1:0] pc,
                                        input logic pce, bsy);
        return {ir, mreq, msel, mw, rw, rd, aop, asrc, ext, wb, pc, pce, bsy};
    endfunction

    // Idle / reset control vector: no strobes, WBSrc=ALU, PCSrc=PC+2.
    function automatic logic [16:0] idle_vec();
        return vec(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b001, 2'b10, 0, 0);
    endfunction

    // Control expected in the execute cycle, from the per-opcode rules.
    function automatic logic [16:0] exec_vec(input logic [4:0] op, input logic fn, fz);
        logic is_call, is_jmp, taken, rw, asrc, ext;
        logic [1:0] aop, pc;
        logic [2:0] wb;
        is_call = op inside {CALLR, CALL};
        is_jmp  = is_call || (op inside {JR, J, JZR, JZ, JNR, JN});
        taken   = (op inside {JR, J, CALLR, CALL}) ||
                  ((op inside {JZR, JZ}) && fz) || ((op inside {JNR, JN}) && fn);
        rw      = is_call || (op inside {MV, ADD, ADDI, SUB, SUBI, MVI, MVHI});
        aop     = (op inside {SUB, SUBI, CMP, CMPI}) ? 2'b01 : 2'b00;
        asrc    = op inside {ADDI, SUBI, CMPI};
        wb      = (op == MV) ? 3'b011 : (op == MVI) ? 3'b100 : (op == MVHI) ? 3'b101 :
                  is_call ? 3'b010 : 3'b001;
        // Immediate-form jumps (bit 4 set) branch via ext imm11, others via register.
        pc      = !(is_jmp && taken) ? 2'b10 : (op[4] ? 2'b00 : 2'b01);
        ext     = is_jmp && taken && op[4];
        return vec(0, 0, 0, 0, rw, is_call, aop, asrc, ext, wb, pc, 1, 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, " flags"}, {30'b0, flag_n, flag_z}, {30'b0, m_fn, m_fz});
        check({tag, " sticky"}, {30'b0, illegal_op, mem_timeout}, {30'b0, m_ill, m_tmo});
        check({tag, " retired"}, retired_count, m_cnt);
    endtask

    // Appends a memory request phase; waits >= TIMEOUT means it never completes.
    task automatic push_req(inout logic [16:0] eq[$], inout logic rq[$], input int w,
                            input logic sel, input logic st_op, output logic tmo);
        tmo = (w >= TB_TIMEOUT);
        for (int i = 0; i < (tmo ? TB_TIMEOUT : w + 1); i++) begin
            logic r;
            r = !tmo && (i == w);
            eq.push_back(vec(r && !sel, 1, sel, st_op, 0, 0, 2'b00, 0, 0, 3'b001, 2'b10, 0, 1));
            rq.push_back(r);
        end
    endtask

    // Runs one instruction from its IDLE cycle back to IDLE, checking every cycle.
    task automatic run_instr(input logic [4:0] op, input logic n, z,
                             input int fw, mw, output int lat);
        logic [16:0] eq[$];
        logic        rq[$];
        logic        tmo, legal, is_mem;
        legal  = 1'b0;
        foreach (legal_ops[i]) if (legal_ops[i] == op) legal = 1'b1;
        is_mem = (op == LD) || (op == ST);

        eq.push_back(idle_vec());
        rq.push_back(1'($urandom_range(0, 1)));
        push_req(eq, rq, fw, 1'b0, 1'b0, tmo);
        if (!tmo) begin
            eq.push_back(vec(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b001, 2'b10, 0, 1));
            rq.push_back(1'($urandom_range(0, 1)));
            eq.push_back(exec_vec(op, m_fn, m_fz));
            rq.push_back(1'($urandom_range(0, 1)));
            if (is_mem) begin
                push_req(eq, rq, mw, 1'b1, op == ST, tmo);
                if (!tmo && op == LD) begin
                    eq.push_back(vec(0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 3'b000, 2'b10, 0, 1));
                    rq.push_back(1'($urandom_range(0, 1)));
                end
            end
            if (!legal) m_ill = 1'b1;
            if (op inside {ADD, SUB, CMP, ADDI, SUBI, CMPI}) begin
                m_fn = n;
                m_fz = z;
            end
        end
        if (tmo) m_tmo = 1'b1;
        else     m_cnt = m_cnt + 1;

        lat = 1;
        for (int k = 0; k < eq.size(); k++) begin
            run       = (k == 0);
            opcode    = op;
            alu_n     = n;
            alu_z     = z;
            mem_ready = rq[k];
            @(negedge clk);
            n_tests++;
            if (outvec !== eq[k]) begin
                n_fail++;
                $display("FAIL ctrl op=%h cyc%0d: got %h expected %h", op, k, outvec, eq[k]);
            end
            if (k > 0 && busy) lat++;
            @(posedge clk);
            #1;
        end
        run       = 1'b0;
        mem_ready = 1'b0;
        check("back to idle", {31'b0, busy}, 32'd0);
        check_status("post");
    endtask

    typedef struct {
        logic [4:0] op;
        logic       n, z;
        int         fw, mw;
        int         lat;
        logic       fn, fz, ill, tmo;
        logic [31:0] cnt;
    } dir_t;

    dir_t tbl [13];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int lat;
        tbl[0]  = '{ADDI, 0, 1, 0, 0, 4, 0, 1, 0, 0, 1};
        tbl[1]  = '{LD,   1, 0, 0, 3, 9, 0, 1, 0, 0, 2};
        tbl[2]  = '{CMP,  0, 1, 0, 0, 4, 0, 1, 0, 0, 3};
        tbl[3]  = '{JZ,   1, 0, 0, 0, 4, 0, 1, 0, 0, 4};
        tbl[4]  = '{CMP,  1, 0, 0, 0, 4, 1, 0, 0, 0, 5};
        tbl[5]  = '{JZ,   0, 1, 0, 0, 4, 1, 0, 0, 0, 6};
        tbl[6]  = '{CALL, 0, 1, 0, 0, 4, 1, 0, 0, 0, 7};
        tbl[7]  = '{ST,   0, 1, 1, 0, 6, 1, 0, 0, 0, 8};
        tbl[8]  = '{5'h1F, 0, 1, 0, 0, 4, 1, 0, 1, 0, 9};
        tbl[9]  = '{MV,   0, 1, 2, 0, 6, 1, 0, 1, 0, 10};
        tbl[10] = '{ADD,  0, 1, TB_TIMEOUT, 0, 9, 1, 0, 1, 1, 10};
        tbl[11] = '{SUBI, 1, 1, 0, 0, 4, 1, 1, 1, 1, 11};
        tbl[12] = '{ST,   0, 0, 0, TB_TIMEOUT, 12, 1, 1, 1, 1, 11};

        // Reset with run and mem_ready high: everything held at reset values.
        reset_n = 1'b0; run = 1'b1; mem_ready = 1'b1; opcode = ADD;
        alu_n = 1'b1; alu_z = 1'b1;
        m_fn = 0; m_fz = 0; m_ill = 0; m_tmo = 0; m_cnt = 0;
        repeat (3) @(negedge clk);
        check("reset ctrl", {15'b0, outvec}, {15'b0, idle_vec()});
        check_status("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Directed table; entry 0 starts in the first cycle out of reset.
        for (int i = 0; i < 13; i++) begin
            run_instr(tbl[i].op, tbl[i].n, tbl[i].z, tbl[i].fw, tbl[i].mw, lat);
            check($sformatf("tbl%0d latency", i), lat, tbl[i].lat);
            check($sformatf("tbl%0d flags", i), {30'b0, flag_n, flag_z},
                  {30'b0, tbl[i].fn, tbl[i].fz});
            check($sformatf("tbl%0d sticky", i), {30'b0, illegal_op, mem_timeout},
                  {30'b0, tbl[i].ill, tbl[i].tmo});
            check($sformatf("tbl%0d retired", i), retired_count, tbl[i].cnt);
        end

        // Reset in the middle of a load: immediate abort, no strobes afterwards.
        run = 1'b1; opcode = LD; mem_ready = 1'b1;
        @(posedge clk); #1; run = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("ld in exec", {31'b0, pc_enable}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("midop reset ctrl", {15'b0, outvec}, {15'b0, idle_vec()});
        m_fn = 0; m_fz = 0; m_ill = 0; m_tmo = 0; m_cnt = 0;
        check_status("midop reset");
        repeat (2) begin
            @(negedge clk);
            check("reset hold ctrl", {15'b0, outvec}, {15'b0, idle_vec()});
        end
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Randomized instruction stream.
        for (int t = 0; t < 200; t++) begin
            logic [4:0] op;
            int fw, mw, r;
            if ($urandom_range(0, 4) == 0) op = 5'($urandom_range(0, 31));
            else                           op = legal_ops[$urandom_range(0, 18)];
            r  = $urandom_range(0, 15);
            fw = (r == 15) ? TB_TIMEOUT : r % 4;
            r  = $urandom_range(0, 15);
            mw = (r == 15) ? TB_TIMEOUT : r % 4;
            run_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), fw, mw, lat);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
